mem_stage_lite: RTL and testbench

- Memory-access pipeline stage between the execute stage and wb_stage.
- Latches execute-stage results and waits for the data-cache load response.
- Aligns and sign/zero-extends load data, then hands the instruction to wb_stage over the valid/allowin handshake.
- Discards cache responses that belong to flushed loads and exposes forwarding/stall info to decode.

---
 rtl/mem_stage_lite.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_stage_lite.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lite.sv
// mem_stage_lite: memory-access pipeline stage between execute and wb_stage.
// Latches execute results, waits for the in-order data-cache load response,
// aligns and extends load data, and hands the instruction to wb_stage.
// Responses for loads killed by a flush are swallowed by a discard counter.
module mem_stage_lite #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    // execute stage side
    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [31:0]      es_pc,
    input  logic [4:0]       es_dest,
    input  logic             es_gr_we,
    input  logic [31:0]      es_result,
    input  logic             es_load,
    input  logic [2:0]       es_mem_op,
    input  logic             es_excp,
    input  logic             es_req_orphan,
    // data cache response
    input  logic             data_ok,
    input  logic [31:0]      data_rdata,
    // wb_stage side
    output logic             ms_to_ws_valid,
    input  logic             ws_allowin,
    output logic [31:0]      ms_pc,
    output logic [4:0]       ms_dest,
    output logic             ms_gr_we,
    output logic [31:0]      ms_final_result,
    output logic             ms_excp,
    input  logic             flush,
    // decode-stage forwarding / interlock
    output logic             ms_fwd_valid,
    output logic             ms_load_stall,
    // state visibility
    output logic [1:0]       ms_dbg_state,
    output logic [CNT_W-1:0] ms_dbg_discard_cnt
);

    // IDLE : no load outstanding (empty, ALU op or excepted load)
    // WAIT : load captured, waiting for its own data_ok
    // HOLD : response received but wb_stage stalled; data kept in r_rdata_buf
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    // Load types
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ms_valid;
    logic [CNT_W-1:0] r_discard_cnt;
    logic [31:0]      r_rdata_buf;

    logic [31:0]      r_pc;
    logic [4:0]       r_dest;
    logic             r_gr_we;
    logic [31:0]      r_result;
    logic             r_load;
    logic [2:0]       r_mem_op;
    logic             r_excp;

    logic             w_resp_hit;
    logic             w_ready_go;
    logic             w_allowin;
    logic             w_capture;
    logic [31:0]      w_load_data;
    logic             w_inc_flush;
    logic             w_dec;
    logic [CNT_W+1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Align and extend a raw cache word according to the load type.
    function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        shifted = rdata >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_B:    res = {{24{byte_v[7]}}, byte_v};
            OP_H:    res = {{16{half_v[15]}}, half_v};
            OP_BU:   res = {24'h000000, byte_v};
            OP_HU:   res = {16'h0000, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Handshake: a payload moves from execute into this stage on a cycle where
    // es_to_ms_valid && ms_allowin, and from this stage into wb_stage on a
    // cycle where ms_to_ws_valid && ws_allowin. Neither valid depends on the
    // corresponding allowin of the same transfer.

    // The response belongs to the current load only when no orphan is pending.
    assign w_resp_hit = (r_state == S_WAIT) && data_ok && (r_discard_cnt == '0);

    assign w_ready_go = !r_ms_valid || !r_load || r_excp || w_resp_hit ||
                        (r_state == S_HOLD);
    assign w_allowin  = !r_ms_valid || (w_ready_go && ws_allowin);
    assign w_capture  = es_to_ms_valid && w_allowin;

    assign w_load_data = load_ext(r_mem_op, r_result[1:0], data_rdata);

    // Discard-counter arithmetic: increments from flush/orphan, netted with a
    // data_ok that is consumed as an orphan response, then saturated.
    always_comb begin
        w_inc_flush = flush && (r_state == S_WAIT) && !w_resp_hit;
        w_dec       = data_ok && (r_discard_cnt != '0);
        w_cnt_sum   = {2'b00, r_discard_cnt}
                    + {{(CNT_W+1){1'b0}}, w_inc_flush}
                    + {{(CNT_W+1){1'b0}}, es_req_orphan}
                    - {{(CNT_W+1){1'b0}}, w_dec};
        w_cnt_nxt   = (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end

    // Next-state logic; flush always wins and returns the stage to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_capture) begin
            w_state_nxt = (es_load && !es_excp) ? S_WAIT : S_IDLE;
        end else if (w_allowin) begin
            w_state_nxt = S_IDLE;
        end else if (w_resp_hit) begin
            // response arrived but wb_stage did not accept it
            w_state_nxt = S_HOLD;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage valid bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
        end else if (flush) begin
            r_ms_valid <= 1'b0;
        end else if (w_capture) begin
            r_ms_valid <= 1'b1;
        end else if (w_allowin) begin
            r_ms_valid <= 1'b0;
        end
    end

    // Payload registers, loaded on every accepted transfer from execute.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc     <= '0;
            r_dest   <= '0;
            r_gr_we  <= 1'b0;
            r_result <= '0;
            r_load   <= 1'b0;
            r_mem_op <= '0;
            r_excp   <= 1'b0;
        end else if (w_capture) begin
            r_pc     <= es_pc;
            r_dest   <= es_dest;
            r_gr_we  <= es_gr_we;
            r_result <= es_result;
            r_load   <= es_load;
            r_mem_op <= es_mem_op;
            r_excp   <= es_excp;
        end
    end

    // Keep the extended load data while wb_stage stalls the completed load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_buf <= '0;
        end else if (!flush && w_resp_hit && !ws_allowin) begin
            r_rdata_buf <= w_load_data;
        end
    end

    // Count of outstanding responses that belong to flushed loads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard_cnt <= '0;
        end else begin
            r_discard_cnt <= w_cnt_nxt;
        end
    end

    // allowin is gated by reset so every output reads 0 while reset is held.
    assign ms_allowin      = resetn && w_allowin;
    assign ms_to_ws_valid  = r_ms_valid && w_ready_go && !flush;
    assign ms_pc           = r_pc;
    assign ms_dest         = r_dest;
    assign ms_gr_we        = r_gr_we;
    assign ms_excp         = r_excp;
    assign ms_final_result = (r_load && !r_excp)
                           ? ((r_state == S_HOLD) ? r_rdata_buf : w_load_data)
                           : r_result;

    assign ms_fwd_valid  = r_ms_valid && r_gr_we && w_ready_go;
    assign ms_load_stall = r_ms_valid && r_gr_we && r_load && !r_excp &&
                           !w_resp_hit && (r_state != S_HOLD);

    assign ms_dbg_state       = r_state;
    assign ms_dbg_discard_cnt = r_discard_cnt;

endmodule

// File: tb/tb_mem_stage_lite.sv
// Testbench for mem_stage_lite: directed scenarios followed by a randomized
// instruction stream checked against a behavioural load-extension model.
module tb_mem_stage_lite;

    localparam int CNT_W = 2;
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_WAIT = 32'd1;
    localparam logic [31:0] ST_HOLD = 32'd2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             es_to_ms_valid;
    logic             ms_allowin;
    logic [31:0]      es_pc;
    logic [4:0]       es_dest;
    logic             es_gr_we;
    logic [31:0]      es_result;
    logic             es_load;
    logic [2:0]       es_mem_op;
    logic             es_excp;
    logic             es_req_orphan;
    logic             data_ok;
    logic [31:0]      data_rdata;
    logic             ms_to_ws_valid;
    logic             ws_allowin;
    logic [31:0]      ms_pc;
    logic [4:0]       ms_dest;
    logic             ms_gr_we;
    logic [31:0]      ms_final_result;
    logic             ms_excp;
    logic             flush;
    logic             ms_fwd_valid;
    logic             ms_load_stall;
    logic [1:0]       ms_dbg_state;
    logic [CNT_W-1:0] ms_dbg_discard_cnt;

    // clock / reset block
    always #5 clk = ~clk;

    mem_stage_lite #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .es_to_ms_valid     (es_to_ms_valid),
        .ms_allowin         (ms_allowin),
        .es_pc              (es_pc),
        .es_dest            (es_dest),
        .es_gr_we           (es_gr_we),
        .es_result          (es_result),
        .es_load            (es_load),
        .es_mem_op          (es_mem_op),
        .es_excp            (es_excp),
        .es_req_orphan      (es_req_orphan),
        .data_ok            (data_ok),
        .data_rdata         (data_rdata),
        .ms_to_ws_valid     (ms_to_ws_valid),
        .ws_allowin         (ws_allowin),
        .ms_pc              (ms_pc),
        .ms_dest            (ms_dest),
        .ms_gr_we           (ms_gr_we),
        .ms_final_result    (ms_final_result),
        .ms_excp            (ms_excp),
        .flush              (flush),
        .ms_fwd_valid       (ms_fwd_valid),
        .ms_load_stall      (ms_load_stall),
        .ms_dbg_state       (ms_dbg_state),
        .ms_dbg_discard_cnt (ms_dbg_discard_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    bit rand_ws  = 1'b0;
    bit mon_en   = 1'b0;

    // scoreboard expected queues
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_excp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ws) ws_allowin = 1'($urandom_range(0, 1));
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_es(input logic [31:0] pc, input logic [4:0] dest,
                            input logic we, input logic [31:0] res,
                            input logic ld, input logic [2:0] op, input logic ex);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_dest        = dest;
        es_gr_we       = we;
        es_result      = res;
        es_load        = ld;
        es_mem_op      = op;
        es_excp        = ex;
    endtask

    // Reference load result computed from the byte/halfword selection rules.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * (addr % 4))) & 32'h0000_00FF;
        h = (d >> (16 * ((addr % 4) / 2))) & 32'h0000_FFFF;
        case (op)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    // scoreboard monitor for the randomized phase
    always @(negedge clk) begin
        if (mon_en && ms_to_ws_valid && ws_allowin) begin
            n_xfer++;
            chk("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("rnd_pc",     ms_pc,           exp_pc_q.pop_front());
                chk("rnd_result", ms_final_result, exp_q.pop_front());
                chk("rnd_excp",   32'(ms_excp),    exp_excp_q.pop_front());
            end
        end
    end

    logic [2:0]  op_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] res;
        logic [2:0]  op;
        int          kind;
        bit          got;

        resetn         = 1'b0;
        es_to_ms_valid = 1'b0;
        es_pc          = '0;
        es_dest        = '0;
        es_gr_we       = 1'b0;
        es_result      = '0;
        es_load        = 1'b0;
        es_mem_op      = '0;
        es_excp        = 1'b0;
        es_req_orphan  = 1'b0;
        data_ok        = 1'b0;
        data_rdata     = '0;
        ws_allowin     = 1'b1;
        flush          = 1'b0;

        // ---------------- reset state
        #2;
        chk("rst_allowin",  32'(ms_allowin),     32'd0);
        chk("rst_to_ws",    32'(ms_to_ws_valid), 32'd0);
        chk("rst_result",   ms_final_result,     32'd0);
        chk("rst_fwd",      32'(ms_fwd_valid),   32'd0);
        chk("rst_stall",    32'(ms_load_stall),  32'd0);
        tick();
        tick();
        resetn = 1'b1;
        settle();
        chk("post_rst_allowin", 32'(ms_allowin), 32'd1);

        // ---------------- ALU op passes in one cycle
        tick();
        drive_es(32'h1c00_0000, 5'd5, 1'b1, 32'h0000_1234, 1'b0, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk("alu_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("alu_result", ms_final_result,     32'h0000_1234);
        chk("alu_gr_we",  32'(ms_gr_we),       32'd1);
        chk("alu_pc",     ms_pc,               32'h1c00_0000);
        chk("alu_dest",   32'(ms_dest),        32'd5);
        chk("alu_fwd",    32'(ms_fwd_valid),   32'd1);
        tick();
        settle();
        chk("alu_drained", 32'(ms_to_ws_valid), 32'd0);

        // ---------------- ld.b at addr ...3, data one cycle later
        tick();
        drive_es(32'h1c00_0004, 5'd6, 1'b1, 32'h0000_1003, 1'b1, 3'b000, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        data_ok        = 1'b1;
        data_rdata     = 32'h80FF_0000;
        settle();
        chk("ldb_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("ldb_result", ms_final_result,     32'hFFFF_FF80);
        chk("ldb_nostall", 32'(ms_load_stall), 32'd0);
        tick();
        data_ok = 1'b0;
        settle();
        chk("ldb_idle", 32'(ms_dbg_state), ST_IDLE);

        // ---------------- ld.hu at addr ...2, one wait cycle then data
        drive_es(32'h1c00_0008, 5'd7, 1'b1, 32'h0000_1002, 1'b1, 3'b101, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk("ldhu_stall", 32'(ms_load_stall),  32'd1);
        chk("ldhu_wait",  32'(ms_to_ws_valid), 32'd0);
        chk("ldhu_fwd",   32'(ms_fwd_valid),   32'd0);
        tick();
        data_ok    = 1'b1;
        data_rdata = 32'h80FF_0000;
        settle();
        chk("ldhu_result", ms_final_result, 32'h0000_80FF);
        tick();
        data_ok = 1'b0;

        // ---------------- HOLD: data_ok while wb_stage stalls for 3 cycles
        drive_es(32'h1c00_000c, 5'd8, 1'b1, 32'h0000_2000, 1'b1, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        data_ok        = 1'b1;
        data_rdata     = 32'hDEAD_BEEF;
        settle();
        chk("hold_resp_allowin", 32'(ms_allowin), 32'd0);
        tick();
        data_ok    = 1'b0;
        data_rdata = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("hold_state",   32'(ms_dbg_state),   ST_HOLD);
            chk("hold_result",  ms_final_result,     32'hDEAD_BEEF);
            chk("hold_allowin", 32'(ms_allowin),     32'd0);
            tick();
        end
        ws_allowin = 1'b1;
        settle();
        chk("hold_release",  32'(ms_to_ws_valid), 32'd1);
        chk("hold_rel_data", ms_final_result,     32'hDEAD_BEEF);
        chk("hold_rel_allow", 32'(ms_allowin),    32'd1);
        tick();
        settle();
        chk("hold_idle", 32'(ms_dbg_state), ST_IDLE);

        // ---------------- back-to-back loads with zero-latency pass-through
        drive_es(32'h1c00_0010, 5'd9, 1'b1, 32'h0000_5000, 1'b1, 3'b010, 1'b0);
        tick();
        drive_es(32'h1c00_0014, 5'd10, 1'b1, 32'h0000_5001, 1'b1, 3'b000, 1'b0);
        data_ok    = 1'b1;
        data_rdata = 32'hA5A5_A5A5;
        settle();
        chk("b2b_a_result",  ms_final_result,  32'hA5A5_A5A5);
        chk("b2b_a_allowin", 32'(ms_allowin),  32'd1);
        tick();
        es_to_ms_valid = 1'b0;
        data_ok        = 1'b0;
        settle();
        chk("b2b_b_wait", 32'(ms_dbg_state), ST_WAIT);
        chk("b2b_b_pc",   ms_pc,             32'h1c00_0014);
        tick();
        data_ok    = 1'b1;
        data_rdata = 32'h0000_7F00;
        settle();
        chk("b2b_b_result", ms_final_result, 32'h0000_007F);
        tick();
        data_ok = 1'b0;

        // ---------------- flush + orphan in WAIT -> two responses discarded
        drive_es(32'h1c00_0018, 5'd11, 1'b1, 32'h0000_3000, 1'b1, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        es_req_orphan  = 1'b1;
        settle();
        chk("flush_to_ws", 32'(ms_to_ws_valid), 32'd0);
        tick();
        flush         = 1'b0;
        es_req_orphan = 1'b0;
        settle();
        chk("flush_cnt",   32'(ms_dbg_discard_cnt), 32'd2);
        chk("flush_state", 32'(ms_dbg_state),       ST_IDLE);
        drive_es(32'h1c00_001c, 5'd12, 1'b1, 32'h0000_4000, 1'b1, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        data_ok        = 1'b1;
        data_rdata     = 32'h1111_1111;
        settle();
        chk("disc1_to_ws", 32'(ms_to_ws_valid), 32'd0);
        tick();
        data_rdata = 32'h2222_2222;
        settle();
        chk("disc2_cnt",   32'(ms_dbg_discard_cnt), 32'd1);
        chk("disc2_to_ws", 32'(ms_to_ws_valid),     32'd0);
        chk("disc2_stall", 32'(ms_load_stall),      32'd1);
        tick();
        data_rdata = 32'h3333_3333;
        settle();
        chk("disc3_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("disc3_result", ms_final_result,     32'h3333_3333);
        tick();
        data_ok = 1'b0;

        // ---------------- flush with own response in the same cycle
        drive_es(32'h1c00_0020, 5'd13, 1'b1, 32'h0000_6000, 1'b1, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        data_ok        = 1'b1;
        data_rdata     = 32'h4444_4444;
        settle();
        chk("fl_ok_to_ws", 32'(ms_to_ws_valid), 32'd0);
        tick();
        flush   = 1'b0;
        data_ok = 1'b0;
        settle();
        chk("fl_ok_cnt", 32'(ms_dbg_discard_cnt), 32'd0);

        // ---------------- orphan saturation and netting
        es_req_orphan = 1'b1;
        repeat (4) tick();
        settle();
        chk("sat_cnt", 32'(ms_dbg_discard_cnt), 32'd3);
        data_ok = 1'b1;
        tick();
        settle();
        chk("net_cnt", 32'(ms_dbg_discard_cnt), 32'd3);
        es_req_orphan = 1'b0;
        repeat (3) tick();
        data_ok = 1'b0;
        settle();
        chk("drain_cnt", 32'(ms_dbg_discard_cnt), 32'd0);

        // ---------------- excepted load passes without waiting
        tick();
        drive_es(32'h1c00_0024, 5'd14, 1'b1, 32'hBAD0_0001, 1'b1, 3'b010, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk("excp_to_ws",  32'(ms_to_ws_valid), 32'd1);
        chk("excp_flag",   32'(ms_excp),        32'd1);
        chk("excp_result", ms_final_result,     32'hBAD0_0001);
        chk("excp_stall",  32'(ms_load_stall),  32'd0);
        tick();

        // ---------------- async reset mid-WAIT with a pending orphan
        drive_es(32'h1c00_0028, 5'd15, 1'b1, 32'h0000_7000, 1'b1, 3'b010, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        es_req_orphan  = 1'b1;
        tick();
        es_req_orphan = 1'b0;
        settle();
        chk("pre_rst_cnt", 32'(ms_dbg_discard_cnt), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_allowin", 32'(ms_allowin),         32'd0);
        chk("arst_pc",      ms_pc,                   32'd0);
        chk("arst_stall",   32'(ms_load_stall),      32'd0);
        chk("arst_cnt",     32'(ms_dbg_discard_cnt), 32'd0);
        chk("arst_result",  ms_final_result,         32'd0);
        tick();
        resetn     = 1'b1;
        data_ok    = 1'b1;
        data_rdata = 32'h5555_5555;
        settle();
        chk("stray_to_ws", 32'(ms_to_ws_valid), 32'd0);
        tick();
        data_ok = 1'b0;
        settle();
        chk("stray_cnt",   32'(ms_dbg_discard_cnt), 32'd0);
        chk("stray_state", 32'(ms_dbg_state),       ST_IDLE);

        // ---------------- randomized stream against the reference model
        tick();
        rand_ws = 1'b1;
        mon_en  = 1'b1;
        for (int t = 0; t < 80; t++) begin
            kind  = int'($urandom_range(0, 3));
            pc    = 32'h1c00_1000 + 32'(4 * t);
            rdata = $urandom;
            op    = op_tab[$urandom_range(0, 4)];
            addr  = $urandom;
            if (op == 3'b001 || op == 3'b101) addr = addr & 32'hFFFF_FFFE;
            if (op == 3'b010) addr = addr & 32'hFFFF_FFFC;
            if (kind == 0) begin
                res = $urandom;
                drive_es(pc, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                         res, 1'b0, 3'b010, 1'b0);
                exp_q.push_back(res);
                exp_excp_q.push_back(32'd0);
            end else if (kind == 3) begin
                drive_es(pc, 5'($urandom_range(1, 31)), 1'b1, addr, 1'b1, op, 1'b1);
                exp_q.push_back(addr);
                exp_excp_q.push_back(32'd1);
            end else begin
                drive_es(pc, 5'($urandom_range(1, 31)), 1'b1, addr, 1'b1, op, 1'b0);
                exp_q.push_back(ref_load(op, addr, rdata));
                exp_excp_q.push_back(32'd0);
            end
            exp_pc_q.push_back(pc);
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                if (ms_allowin) got = 1'b1;
                tick();
            end
            es_to_ms_valid = 1'b0;
            chk("rnd_capture", 32'(got), 32'd1);
            if (kind == 1 || kind == 2) begin
                repeat ($urandom_range(0, 3)) tick();
                data_ok    = 1'b1;
                data_rdata = rdata;
                tick();
                data_ok    = 1'b0;
                data_rdata = $urandom;
            end
        end
        rand_ws    = 1'b0;
        ws_allowin = 1'b1;
        repeat (5) tick();
        settle();
        mon_en = 1'b0;
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_xfers",   32'(n_xfer),       32'd80);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
